// File: rtl/led_pattern_seq.sv
// LED pattern engine stepped by both edges of an asynchronous toggling tick.
// Optional PWM dimming stage enabled by defining LED_PATTERN_SEQ_PWM_EN.
module led_pattern_seq #(
  parameter int unsigned NUM_LEDS    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_in,
  input  logic                enable,
  input  logic [1:0]          mode,
`ifdef LED_PATTERN_SEQ_PWM_EN
  input  logic [7:0]          duty,
`endif
  output logic [NUM_LEDS-1:0] led,
  output logic                step
);

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BINARY = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [NUM_LEDS-1:0] ONE        = NUM_LEDS'(1);
  localparam logic [2:0]          GUARD_LOAD = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic                   hist;
  logic                   tick_edge;
  logic                   edge_q;
  logic [2:0]             guard_cnt;
  logic                   guard_done;

  mode_e                  mode_q, mode_d, mode_in;
  dir_e                   dir_q, dir_d;
  logic [NUM_LEDS-1:0]    pattern_q, pattern_d;
  logic [NUM_LEDS-1:0]    shifted;
  logic                   onehot;
  logic                   fire;
  logic                   step_q;

  assign sync_out   = sync[SYNC_STAGES-1];
  assign tick_edge  = sync_out ^ hist;
  assign guard_done = (guard_cnt == 3'd0);
  assign mode_in    = mode_e'(mode);
  assign onehot     = (pattern_q != '0) &&
                      ((pattern_q & (pattern_q - ONE)) == '0);

  // edge_q adds one pipeline stage so a step lands SYNC_STAGES+1 edges after sampling
  assign fire = edge_q & enable;

  always_comb begin
    pattern_d = pattern_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    shifted   = '0;
    if (fire) begin
      if (mode_in != mode_q) begin
        mode_d = mode_in;
        dir_d  = DIR_LEFT;
        case (mode_in)
          MODE_ROTATE: pattern_d = ONE;
          MODE_BOUNCE: pattern_d = ONE;
          MODE_BINARY: pattern_d = '0;
          MODE_BLINK:  pattern_d = '1;
        endcase
      end else begin
        case (mode_q)
          MODE_ROTATE: begin
            if (!onehot) begin
              pattern_d = ONE;
              dir_d     = DIR_LEFT;
            end else begin
              pattern_d = {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
            end
          end
          MODE_BOUNCE: begin
            if (!onehot) begin
              pattern_d = ONE;
              dir_d     = DIR_LEFT;
            end else begin
              // Direction flips on arrival at an end so the end LED dwells one step only
              shifted   = (dir_q == DIR_LEFT) ? (pattern_q << 1) : (pattern_q >> 1);
              pattern_d = shifted;
              if (shifted[NUM_LEDS-1])
                dir_d = DIR_RIGHT;
              else if (shifted[0])
                dir_d = DIR_LEFT;
            end
          end
          MODE_BINARY: pattern_d = pattern_q + ONE;
          MODE_BLINK:  pattern_d = ~pattern_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= '0;
      hist      <= 1'b0;
      edge_q    <= 1'b0;
      guard_cnt <= GUARD_LOAD;
      mode_q    <= MODE_ROTATE;
      dir_q     <= DIR_LEFT;
      pattern_q <= ONE;
      step_q    <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], tick_in};
      hist      <= sync_out;
      edge_q    <= tick_edge & guard_done;
      if (!guard_done)
        guard_cnt <= guard_cnt - 3'd1;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      pattern_q <= pattern_d;
      step_q    <= fire;
    end
  end

`ifdef LED_PATTERN_SEQ_PWM_EN
  logic [7:0]          pwm_cnt;
  logic [NUM_LEDS-1:0] led_q;
  logic                step_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      led_q   <= ONE;
      step_d  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      led_q   <= pattern_q & {NUM_LEDS{pwm_cnt < duty}};
      step_d  <= step_q;
    end
  end

  assign led  = led_q;
  assign step = step_d;
`else
  assign led  = pattern_q;
  assign step = step_q;
`endif

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
Sits downstream of the board's LED blink-rate generator and consumes its toggling square wave as a step clock. Every edge of that wave, rising or falling, advances an LED pattern engine. The engine drives the board's user LEDs. Patterns are mode-selectable: rotate, bounce, binary count and all-blink.

Parameters:
NUM_LEDS, 8, number of LED outputs; legal range 2..32.
SYNC_STAGES, 2, flops in the tick_in synchronizer; legal range 2..4.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
tick_in  in  1  level-toggling step source from the blink generator; treated as asynchronous.
enable  in  1  1 = steps advance the pattern; 0 = pattern frozen.
mode  in  2  0 = rotate, 1 = bounce, 2 = binary count, 3 = all-blink.
led  out  NUM_LEDS  pattern output, registered.
step  out  1  one-cycle pulse, high in the same cycle that led takes a new value.

Behaviour:
- Reset (rst=1 at a clk edge) sets the following; rst has priority over every other event in the same cycle:
  - led = 1 (bit 0 only)
  - step = 0
  - direction = LEFT
  - synchronizer flops and edge-history flop = 0
  - mode_q = 0
  - guard counter loaded
- Guard: for the first SYNC_STAGES+1 clk edges after rst deasserts, edge detection is suppressed. This prevents a spurious step when tick_in is already 1 at reset.
- Edge detect:
  - sync_out = last synchronizer stage; hist = sync_out delayed 1 clk.
  - edge = sync_out XOR hist.
  - A tick_in toggle sampled at edge k updates led and asserts step at edge k+SYNC_STAGES+1 (3 edges for the default).
- Step condition: edge AND enable AND guard expired. Edges while enable=0 are discarded, not queued.
- mode is sampled only on a step.
  - If mode != mode_q, the step loads the initial pattern of the new mode and sets mode_q = mode. No advance happens on that step.
  - Initial patterns: rotate = 1, direction LEFT; bounce = 1, direction LEFT; binary = 0; all-blink = all ones.
- Rotate: led = {led[NUM_LEDS-2:0], led[NUM_LEDS-1]}, so bit MSB wraps to bit 0.
- Bounce: exactly one bit set.
  - LEFT shifts toward the MSB; RIGHT shifts toward bit 0.
  - On reaching bit NUM_LEDS-1, direction becomes RIGHT and the next step moves to NUM_LEDS-2.
  - On reaching bit 0, direction becomes LEFT.
  - The end LED lights for exactly one step (no double dwell).
- Binary: led = led + 1, modulo 2^NUM_LEDS. All ones wraps to 0.
- All-blink: led = ~led.
- Recovery: if led is ever not one-hot in rotate or bounce (e.g. after a mode decode fault), the next step loads 1 with direction LEFT.
- step is high for exactly one cycle per accepted step. step is never high while rst=1 or enable=0.
- Reset mid-operation: all state returns to reset values on the next edge, and the guard restarts.

Optional Feature:
Macro LED_PATTERN_SEQ_PWM_EN.
- Defined:
  - Adds input port duty [7:0] and an internal 8-bit free-running counter pwm_cnt, reset to 0.
  - led = pattern_q AND {NUM_LEDS{pwm_cnt < duty}}, registered; adds 1 cycle of latency on led only.
  - step is delayed 1 cycle so it stays aligned with led.
  - duty = 0 gives LEDs off; duty = 255 gives on for 255 of every 256 cycles.
- Not defined: no duty port; led = pattern_q directly; latency as specified above.

Test Plan:
1. Reset, NUM_LEDS=4, tick_in held 1 through reset release -> no step pulse; led stays 4'b0001.
2. mode=0, enable=1, 5 tick_in toggles spaced 20 clk -> led 0010, 0100, 1000, 0001, 0010. Each step occurs exactly 3 clk after the toggle is sampled.
3. mode=1, 8 steps from reset -> first step loads 0001 with no step advance (mode change), then 0010, 0100, 1000, 0100, 0010, 0001, 0010.
4. mode=2, 17 steps -> after mode-load step led = 0; after 15 more steps led = 1111; next step led = 0000.
5. enable=0 for 3 toggles, then enable=1 plus 1 toggle -> led unchanged and step low during disabled toggles; exactly one advance afterwards.
6. LED_PATTERN_SEQ_PWM_EN build, mode=3, duty=64, led pattern all ones -> each LED high for 64 of every 256 clk; duty=0 keeps led all 0.
